// File: rtl/skolem_bvand_ne_sweep_checker.sv
// rtl/skolem_bvand_ne_sweep_checker.sv - exhaustive sweep checker for the (x & s) != t Skolem block
// Optional STOP_ON_FAIL_EN: end the sweep at the first failing vector.
module skolem_bvand_ne_sweep_checker #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   sk_s,
    output logic [WIDTH-1:0]   sk_t,
    input  logic [WIDTH-1:0]   sk_x,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   ic_count,
    output logic [2*WIDTH:0]   err_count,
    output logic [WIDTH-1:0]   fail_s,
    output logic [WIDTH-1:0]   fail_t,
    output logic [WIDTH-1:0]   fail_x
);

    localparam int VW = 2*WIDTH + 1;
    localparam logic [VW-1:0] LAST = VW'((1 << (2*WIDTH)) - 1);
    localparam logic [VW-1:0] SAT  = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [VW-1:0]    r_v;
    logic [WIDTH-1:0] r_sk_s;
    logic [WIDTH-1:0] r_sk_t;
    logic             r_chk_valid;
    logic [VW-1:0]    r_ic;
    logic [VW-1:0]    r_err;
    logic [WIDTH-1:0] r_fail_s;
    logic [WIDTH-1:0] r_fail_t;
    logic [WIDTH-1:0] r_fail_x;

    logic w_start_ok;
    logic w_ic;
    logic w_fail;
    logic w_first;
    logic w_stop;
    logic w_issue;

    // The vector on sk_s/sk_t was issued last edge; sk_x answers it now.
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_ic       = (r_sk_s != '0) || (r_sk_t != '0);
    assign w_fail     = r_chk_valid && w_ic && ((sk_x & r_sk_s) == r_sk_t);
    assign w_first    = w_fail && (r_err == '0);

`ifdef STOP_ON_FAIL_EN
    assign w_stop = w_fail;
`else
    assign w_stop = 1'b0;
`endif

    assign w_issue = (r_state == S_RUN) && !w_stop;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN: begin
                if (w_stop)
                    w_next = S_DONE;
                else if (r_v == LAST)
                    w_next = S_DRAIN;
            end
            S_DRAIN: if (w_stop || !r_chk_valid) w_next = S_DONE;
            S_DONE:  if (start) w_next = S_RUN;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v         <= '0;
            r_sk_s      <= '0;
            r_sk_t      <= '0;
            r_chk_valid <= 1'b0;
            r_ic        <= '0;
            r_err       <= '0;
            r_fail_s    <= '0;
            r_fail_t    <= '0;
            r_fail_x    <= '0;
        end else if (w_start_ok) begin
            r_v         <= '0;
            r_chk_valid <= 1'b0;
            r_ic        <= '0;
            r_err       <= '0;
            r_fail_s    <= '0;
            r_fail_t    <= '0;
            r_fail_x    <= '0;
        end else begin
            // A stop discards anything already issued by clearing the check stage.
            r_chk_valid <= w_issue;
            if (w_issue) begin
                {r_sk_t, r_sk_s} <= r_v[2*WIDTH-1:0];
                r_v              <= r_v + 1'b1;
            end
            if (r_chk_valid && w_ic && (r_ic != SAT))
                r_ic <= r_ic + 1'b1;
            if (w_fail && (r_err != SAT))
                r_err <= r_err + 1'b1;
            if (w_first) begin
                r_fail_s <= r_sk_s;
                r_fail_t <= r_sk_t;
                r_fail_x <= sk_x;
            end
        end
    end

    assign sk_s      = r_sk_s;
    assign sk_t      = r_sk_t;
    assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);
    assign pass      = done && (r_err == '0);
    assign ic_count  = r_ic;
    assign err_count = r_err;
    assign fail_s    = r_fail_s;
    assign fail_t    = r_fail_t;
    assign fail_x    = r_fail_x;

endmodule

// File: tb/tb_skolem_bvand_ne_sweep_checker.sv
// tb/tb_skolem_bvand_ne_sweep_checker.sv - randomized self-checking bench for the sweep checker
module tb_skolem_bvand_ne_sweep_checker;

    localparam int N = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] sk_s, sk_t, sk_x;
    logic       busy, done, pass;
    logic [8:0] ic_count, err_count;
    logic [3:0] fail_s, fail_t, fail_x;

    logic [3:0] xtab [N];

    int errors = 0;
    int checks = 0;

    int         e_ic, e_err, e_done;
    logic [3:0] e_fs, e_ft, e_fx;

    always #5 clk = ~clk;

    // Behavioural Skolem block: a lookup table indexed by {t,s}.
    assign sk_x = xtab[{sk_t, sk_s}];

    skolem_bvand_ne_sweep_checker #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .sk_s(sk_s), .sk_t(sk_t), .sk_x(sk_x),
        .busy(busy), .done(done), .pass(pass),
        .ic_count(ic_count), .err_count(err_count),
        .fail_s(fail_s), .fail_t(fail_t), .fail_x(fail_x)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: x=~t (always valid), 1: x=0, 2: valid but x=F at s=t=0,
    // 3: fully random x, 4: valid with sparse random corruption
    task automatic fill(input int mode);
        for (int i = 0; i < N; i++) begin
            logic [3:0] t;
            t = 4'(i / 16);
            case (mode)
                0: xtab[i] = ~t;
                1: xtab[i] = 4'h0;
                2: xtab[i] = (i == 0) ? 4'hF : ~t;
                3: xtab[i] = 4'($urandom_range(0, 15));
                default: xtab[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : ~t;
            endcase
        end
    endtask

    task automatic model();
        e_ic = 0; e_err = 0; e_done = N + 2;
        e_fs = 4'h0; e_ft = 4'h0; e_fx = 4'h0;
        for (int v = 0; v < N; v++) begin
            int s, t;
            s = v % 16;
            t = v / 16;
            if (s != 0 || t != 0) begin
                e_ic++;
                if ((int'(xtab[v]) & s) == t) begin
                    if (e_err == 0) begin
                        e_fs = 4'(s); e_ft = 4'(t); e_fx = xtab[v];
                    end
                    e_err++;
`ifdef STOP_ON_FAIL_EN
                    e_done = v + 2;
                    break;
`endif
                end
            end
        end
    endtask

    task automatic run_sweep(input string name, input bit poke);
        int dc;
        model();
        dc = -1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin
                check({name, ":busy_c1"}, busy, 1);
                check({name, ":ic_c1"}, ic_count, 0);
                check({name, ":err_c1"}, err_count, 0);
            end
            start = poke && (cyc == 5 || cyc == 50);
            if (done) begin
                dc = cyc;
                break;
            end
        end
        start = 1'b0;
        check({name, ":done_cycle"}, dc, e_done);
        check({name, ":busy_at_done"}, busy, 0);
        check({name, ":pass"}, pass, (e_err == 0) ? 1 : 0);
        check({name, ":ic_count"}, ic_count, e_ic);
        check({name, ":err_count"}, err_count, e_err);
        check({name, ":fail_s"}, fail_s, e_fs);
        check({name, ":fail_t"}, fail_t, e_ft);
        check({name, ":fail_x"}, fail_x, e_fx);
`ifndef STOP_ON_FAIL_EN
        check({name, ":sk_hold"}, {sk_t, sk_s}, 8'hFF);
`endif
    endtask

    task automatic check_zero(input string name);
        check({name, ":busy"}, busy, 0);
        check({name, ":done"}, done, 0);
        check({name, ":pass"}, pass, 0);
        check({name, ":counts"}, {ic_count, err_count}, 0);
        check({name, ":sk"}, {sk_t, sk_s}, 0);
        check({name, ":fail"}, {fail_s, fail_t, fail_x}, 0);
    endtask

    initial begin
        fill(0);
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        rst_n = 1'b1;

        fill(0); run_sweep("T1_correct", 1'b0);
        fill(1); run_sweep("T2_zero", 1'b0);
        fill(2); run_sweep("T4_icfalse", 1'b0);
        fill(3); run_sweep("R_random", 1'b0);
        fill(4); run_sweep("R_sparse_a", 1'b0);
        fill(4); run_sweep("R_sparse_b", 1'b0);

        // Reset in the middle of a sweep.
        fill(0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (100) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("T5_async");
        repeat (2) @(posedge clk);
        #1 check_zero("T5_held");
        rst_n = 1'b1;
        run_sweep("T5_after", 1'b0);

        fill(0); run_sweep("T6_poke", 1'b1);
        run_sweep("T6_restart", 1'b0);
        fill(1); run_sweep("T6_restart_bad", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
